axis_accumulator_mc: RTL
========================

# axis_accumulator_mc

Multi-channel AXI4-Stream block accumulator that sums `cfg_data+1` consecutive input beats independently per channel and emits one output beat per block. It sits after ADC/decimator stages, where several parallel lanes (I/Q, multiple ADC inputs) arrive in one beat. Unlike single-lane accumulators, it applies lossless backpressure instead of overwriting an unread result. It also exposes a completed-block counter for software polling.

## Interface
- `CHANNELS`, 2: number of lanes packed in each beat (≥1).
- `S_AXIS_TDATA_WIDTH`, 16: input width per lane.
- `M_AXIS_TDATA_WIDTH`, 32: output/accumulator width per lane (≥ `S_AXIS_TDATA_WIDTH`).
- `CNTR_WIDTH`, 16: beat-counter and `cfg_data` width.
- `AXIS_TDATA_SIGNED`, "FALSE": "TRUE" sign-extends lane inputs; otherwise they are zero-extended.
- `CONTINUOUS`, "FALSE": "TRUE" restarts after every block; "FALSE" stops after the first block until reset.
- `STS_WIDTH`, 32: width of the block counter.

- `aclk`  in  1  clock; all logic on rising edge.
- `aresetn`  in  1  asynchronous, active-low reset.
- `cfg_data`  in  CNTR_WIDTH  block length minus one (N = cfg_data+1 beats).
- `sts_data`  out  STS_WIDTH  number of output beats emitted (handshaken) since reset.
- `s_axis_tdata`  in  CHANNELS*S_AXIS_TDATA_WIDTH  lane k at bits [k*S +: S].
- `s_axis_tvalid`  in  1  input valid.
- `s_axis_tready`  out  1  input ready.
- `m_axis_tdata`  out  CHANNELS*M_AXIS_TDATA_WIDTH  lane k sum at bits [k*M +: M].
- `m_axis_tvalid`  out  1  output valid.
- `m_axis_tready`  in  1  output ready.

## Operation
- State: `run_reg`, `cntr_reg`, `len_reg`, per-lane `accu_reg[k]`, output holding register, `tvalid_reg`, and `sts_reg`.
- Accept = `s_axis_tvalid & s_axis_tready`.
- `last` = (`cntr_reg==0` ? `cfg_data` : `len_reg`) == `cntr_reg`.
- When `cntr_reg==0` and a beat is accepted, `len_reg` is loaded from `cfg_data`. `cfg_data` is therefore sampled only at block start, and mid-block changes affect the next block.
- Accept and not last:
  - `accu[k] <= accu[k] + ext(lane k)`.
  - `cntr_reg` increments.
- Accept and last:
  - Output register is loaded with `accu[k] + ext(lane k)`, and `tvalid_reg` is set.
  - `accu` and `cntr_reg` clear to 0.
  - If STOP mode, `run_reg` clears.
- `cfg_data=0`: each accepted beat is its own block, and the output equals the input extended.
- Arithmetic is modular in M bits, with no saturation. Overflow wraps silently.
- Ready rule: `s_axis_tready = run_reg & ~(tvalid_reg & ~m_axis_tready)`.
  - This is a combinational path from `m_axis_tready`.
  - The rule ensures no result is ever overwritten or dropped.
- Output handshake (`m_axis_tvalid & m_axis_tready`):
  - `tvalid_reg` clears unless a new last beat is accepted in the same cycle. In that case it stays 1 and the data updates.
  - `sts_reg` increments, wrapping at 2^STS_WIDTH.
- STOP mode: after the first block, `s_axis_tready` stays 0 and the pending result remains valid until taken. The block stays idle until `aresetn` is asserted.

## Timing
- Reset (async assert, synchronous-release behaviour on next edge):
  - `m_axis_tvalid=0`, `m_axis_tdata=0`, `s_axis_tready=0`, `sts_data=0`.
  - All accumulators and counters are 0.
- `run_reg` sets on the first rising edge with `aresetn=1`, so `s_axis_tready` goes high one cycle after reset release.
- Reset asserted mid-block discards the partial sums and any pending output immediately.
- Throughput is one beat per cycle. In CONTINUOUS mode, back-to-back blocks have no idle cycle when `m_axis_tready=1`.
- Latency: `m_axis_tvalid` rises on the edge that accepts the last beat, so the result is visible the cycle after that beat is presented.
- `sts_data` updates on the edge of the output handshake.
- Stall: if the last beat of block n+1 arrives while result n is unread and `m_axis_tready=0`, `s_axis_tready` is low. The beat is held upstream, and it is accepted in the cycle `m_axis_tready` rises.

## Test plan
- Unsigned, CHANNELS=2, `cfg_data=3`, lanes (1,10),(2,20),(3,30),(4,40), `m_axis_tready=1` → one beat (10,100), `m_axis_tvalid` high for 1 cycle, `sts_data=1`.
- Signed, S=16/M=32, `cfg_data=1`, lane0 inputs 0x8000,0xFFFF → 0xFFFF7FFF (−32769). Unsigned run with the same inputs → 0x00017FFF.
- CONTINUOUS, `cfg_data=0`, `m_axis_tready=0` for 5 cycles with tvalid held → first result valid, `s_axis_tready=0` thereafter. No beat is lost: output sequence equals input sequence once ready rises, and `sts_data` counts every beat.
- STOP mode, `cfg_data=2`, 6 beats offered → only the first 3 are summed, and `s_axis_tready` stays 0 afterwards. After an `aresetn` pulse, the next 3 are summed.
- `cfg_data` changed from 3 to 1 after beat 2 of a block → current block still sums 4 beats, next block sums 2.
- `aresetn` asserted after 2 of 4 beats → outputs 0 immediately. A fresh block after release contains no residue.

Source files
------------

// File: rtl/axis_accumulator_mc_if.sv
// AXI4-Stream style bundle (tdata/tvalid/tready) used on both sides of the accumulator.
// Latency: none, wires only.
// Backpressure: tready flows from the slave side back to the master side.
interface axis_accumulator_mc_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_accumulator_mc.sv
// Multi-lane block accumulator: sums cfg_data+1 beats per lane and emits one beat per block.
// Latency: the result is valid from the edge that accepts the last beat of a block.
// Backpressure: input stalls while an unread result is pending and downstream is not ready.
module axis_accumulator_mc #(
  parameter int    CHANNELS           = 2,
  parameter int    S_AXIS_TDATA_WIDTH = 16,
  parameter int    M_AXIS_TDATA_WIDTH = 32,
  parameter int    CNTR_WIDTH         = 16,
  parameter string AXIS_TDATA_SIGNED  = "FALSE",
  parameter string CONTINUOUS         = "FALSE",
  parameter int    STS_WIDTH          = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [CNTR_WIDTH-1:0] cfg_data,
  output logic [STS_WIDTH-1:0]  sts_data,
  axis_accumulator_mc_if.slave  s_axis,
  axis_accumulator_mc_if.master m_axis
);
  localparam int S = S_AXIS_TDATA_WIDTH;
  localparam int M = M_AXIS_TDATA_WIDTH;
  localparam bit IS_SIGNED = (AXIS_TDATA_SIGNED == "TRUE");
  localparam bit IS_CONT   = (CONTINUOUS == "TRUE");

  // IDLE only lasts the first edge after reset; DONE is the STOP-mode terminal state.
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t                  state_reg;
  state_t                  state_next;
  logic                    run_reg;
  logic [CNTR_WIDTH-1:0]   cntr_reg;
  logic [CNTR_WIDTH-1:0]   len_reg;
  logic [CNTR_WIDTH-1:0]   len_eff;
  logic [M-1:0]            accu_reg [CHANNELS];
  logic [M-1:0]            accu_sum [CHANNELS];
  logic [CHANNELS*M-1:0]   lane_ext;
  logic [CHANNELS*M-1:0]   out_reg;
  logic                    tvalid_reg;
  logic [STS_WIDTH-1:0]    sts_reg;
  logic                    accept;
  logic                    last;
  logic                    out_hs;
  logic                    ready;

  assign run_reg = (state_reg == ST_RUN);

  // Ready drops only when a pending result would otherwise be overwritten.
  assign ready  = run_reg & ~(tvalid_reg & ~m_axis.tready);
  assign accept = s_axis.tvalid & ready;
  assign out_hs = tvalid_reg & m_axis.tready;

  // The block length is latched at block start; until then the live cfg_data applies.
  assign len_eff = (cntr_reg == '0) ? cfg_data : len_reg;
  assign last    = (len_eff == cntr_reg);

  // Widen each input lane to accumulator width.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    logic [S-1:0] lane;
    assign lane = s_axis.tdata[k*S +: S];
    if (IS_SIGNED) begin : g_sx
      assign lane_ext[k*M +: M] = M'($signed(lane));
    end else begin : g_zx
      assign lane_ext[k*M +: M] = M'(lane);
    end
  end

  // Running sum including the beat currently presented; wraps modulo 2^M.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      accu_sum[k] = accu_reg[k] + lane_ext[k*M +: M];
    end
  end

  // Run-state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Run-state transitions: start after reset, stop after the first block unless continuous.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: state_next = ST_RUN;
      ST_RUN: begin
        if (accept && last && !IS_CONT) begin
          state_next = ST_DONE;
        end
      end
      default: state_next = state_reg;
    endcase
  end

  // Beat counter, latched length and per-lane partial sums.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cntr_reg <= '0;
      len_reg  <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        accu_reg[k] <= '0;
      end
    end else if (accept) begin
      if (cntr_reg == '0) begin
        len_reg <= cfg_data;
      end
      if (last) begin
        cntr_reg <= '0;
        for (int k = 0; k < CHANNELS; k++) begin
          accu_reg[k] <= '0;
        end
      end else begin
        cntr_reg <= cntr_reg + CNTR_WIDTH'(1);
        for (int k = 0; k < CHANNELS; k++) begin
          accu_reg[k] <= accu_sum[k];
        end
      end
    end
  end

  // Output holding register; a new result may replace one being taken in the same cycle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_reg    <= '0;
      tvalid_reg <= 1'b0;
    end else if (accept && last) begin
      for (int k = 0; k < CHANNELS; k++) begin
        out_reg[k*M +: M] <= accu_sum[k];
      end
      tvalid_reg <= 1'b1;
    end else if (out_hs) begin
      tvalid_reg <= 1'b0;
    end
  end

  // Completed-block counter, counting output handshakes.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sts_reg <= '0;
    end else if (out_hs) begin
      sts_reg <= sts_reg + STS_WIDTH'(1);
    end
  end

  assign s_axis.tready = ready;
  assign m_axis.tvalid = tvalid_reg;
  assign m_axis.tdata  = out_reg;
  assign sts_data      = sts_reg;
endmodule
